// File: rtl/dac.sv
// dac: serial writer for a bank of 8 independent 16-bit SPI DACs.
// All 8 lanes share sclk/sync_n and shift out simultaneously, MSB first,
// one sdi line per DAC. Lane i of the input word is data[16*i+15:16*i].
//
// Optional feature macro: DAC_LDAC_EN adds the ldac_n port. ldac_n is driven
// low for the last HOLD cycle so that all DACs update together.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   data       8 x 16-bit codes to send
//   data_valid data holds a word to send
//   data_ready block idle; word taken on an edge with data_valid & data_ready
//   done       one-cycle pulse in the first HOLD cycle of a finished frame
//   sdi        serial data, sdi[i] carries lane i
//   sclk       serial clock, idles low; DACs latch sdi on its falling edge
//   sync_n     frame select, active low
//   ldac_n     load strobe, active low (DAC_LDAC_EN only)
module dac #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data,
    input  logic         data_valid,
    output logic         data_ready,
    output logic         done,
    output logic [7:0]   sdi,
    output logic         sclk,
    output logic         sync_n
`ifdef DAC_LDAC_EN
    ,
    output logic         ldac_n
`endif
);

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned HALF_W = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0]  LAST_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_HOLD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [HALF_W-1:0] LAST_HALF  = HALF_W'(2 * LANE_W - 1);

    // Parameter sanity checks at elaboration
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 256) begin : g_bad_setup
        $error("dac: SETUP_CYCLES must be in 1..256");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 256) begin : g_bad_hold
        $error("dac: HOLD_CYCLES must be in 1..256");
    end
`ifdef DAC_LDAC_EN
    if (HOLD_CYCLES < 2) begin : g_bad_ldac_hold
        $error("dac: HOLD_CYCLES must be >= 2 when DAC_LDAC_EN is defined");
    end
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [HALF_W-1:0]   half, half_d;
    logic [WORD_W-1:0]   shreg, shreg_d;
    logic [LANES-1:0]    sdi_d;
    logic                sclk_d, sync_n_d, done_d;
`ifdef DAC_LDAC_EN
    logic                ldac_d;
`endif

    // MSB of every lane, i.e. the bit currently presented on each sdi line
    function automatic logic [LANES-1:0] lane_msbs(input logic [WORD_W-1:0] w);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = w[LANE_W*i + LANE_W - 1];
        end
        return m;
    endfunction

    // Shift each lane left by one independently (no bleed between lanes)
    function automatic logic [WORD_W-1:0] lane_shift(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] s;
        for (int i = 0; i < LANES; i++) begin
            s[LANE_W*i +: LANE_W] = {w[LANE_W*i +: LANE_W-1], 1'b0};
        end
        return s;
    endfunction

    assign data_ready = (state == IDLE);

    // State, counters and pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half   <= '0;
            shreg  <= '0;
            sdi    <= '0;
            sclk   <= 1'b0;
            sync_n <= 1'b1;
            done   <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n <= 1'b1;
`endif
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            half   <= half_d;
            shreg  <= shreg_d;
            sdi    <= sdi_d;
            sclk   <= sclk_d;
            sync_n <= sync_n_d;
            done   <= done_d;
`ifdef DAC_LDAC_EN
            ldac_n <= ldac_d;
`endif
        end
    end

    // Next state and next pin values; pins always reflect the state being entered
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        half_d   = half;
        shreg_d  = shreg;
        sdi_d    = sdi;
        sclk_d   = 1'b0;
        sync_n_d = 1'b1;
        done_d   = 1'b0;
`ifdef DAC_LDAC_EN
        ldac_d   = 1'b1;
`endif
        case (state)
            IDLE: begin
                sdi_d = '0;
                if (data_valid) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    shreg_d  = data;
                    sync_n_d = 1'b0;
                    sdi_d    = lane_msbs(data);
                end
            end
            SETUP: begin
                sync_n_d = 1'b0;
                if (cnt == LAST_SETUP) begin
                    state_d = SHIFT;
                    half_d  = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (half == LAST_HALF) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    sdi_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    sync_n_d = 1'b0;
                    half_d   = half + HALF_W'(1);
                    // Odd half-cycle ends a bit; next bit appears as sclk rises
                    sclk_d   = half[0];
                    if (half[0]) begin
                        shreg_d = lane_shift(shreg);
                        sdi_d   = lane_msbs(lane_shift(shreg));
                    end
                end
            end
            HOLD: begin
                sdi_d = '0;
                if (cnt == LAST_HOLD) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
`ifdef DAC_LDAC_EN
                    ldac_d = (cnt_d == LAST_HOLD) ? 1'b0 : 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac.sv
// tb_dac: directed + randomized bench for dac. A per-lane DAC model decodes
// the serial pins back into words, compared against the words handed over.
module tb_dac;

    localparam int unsigned S0 = 1;
    localparam int unsigned H0 = 2;
    localparam int unsigned S1 = 3;
    localparam int unsigned H1 = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data0, data1;
    logic         valid0, valid1;
    logic         ready0, ready1, done0, done1;
    logic         sclk0, sclk1, sync0, sync1;
    logic [7:0]   sdi0, sdi1;
`ifdef DAC_LDAC_EN
    logic         ldac0, ldac1;
`endif

    always #5 clk = ~clk;

    dac #(.SETUP_CYCLES(S0), .HOLD_CYCLES(H0)) u0 (
        .clk(clk), .rst(rst), .data(data0), .data_valid(valid0),
        .data_ready(ready0), .done(done0), .sdi(sdi0), .sclk(sclk0),
        .sync_n(sync0)
`ifdef DAC_LDAC_EN
        , .ldac_n(ldac0)
`endif
    );

    dac #(.SETUP_CYCLES(S1), .HOLD_CYCLES(H1)) u1 (
        .clk(clk), .rst(rst), .data(data1), .data_valid(valid1),
        .data_ready(ready1), .done(done1), .sdi(sdi1), .sclk(sclk1),
        .sync_n(sync1)
`ifdef DAC_LDAC_EN
        , .ldac_n(ldac1)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- DAC model on u0 pins ----------------
    logic [127:0] dec_q[$];
    logic [127:0] exp_q[$];
    logic [15:0]  sh [8];
    int mc = 0, falls = 0, rises = 0, aborts = 0, dones = 0, stray = 0;
    int fall_cyc = 0, rise_cyc = -1, first_rise_cyc = -1, done_cyc = -1;
    int last_lowlen = 0, last_first_rise = 0, last_gap = 0;
    int ldac_lows = 0, ldac_cyc = -1, ldac_bad = 0;
    logic       p_sclk = 1'b0, p_sync = 1'b1;
    logic [7:0] p_sdi = '0;

    always @(posedge clk) begin
        logic [127:0] w;
        #2;
        mc++;
        if (done0 === 1'b1) begin
            dones++;
            done_cyc = mc;
        end
`ifdef DAC_LDAC_EN
        if (ldac0 === 1'b0) begin
            ldac_lows++;
            ldac_cyc = mc;
            if (sync0 !== 1'b1) ldac_bad++;
        end
`endif
        if (p_sync && !sync0) begin
            falls = 0;
            rises = 0;
            fall_cyc = mc;
            first_rise_cyc = -1;
            if (rise_cyc >= 0) last_gap = mc - rise_cyc;
        end
        if (!p_sclk && sclk0) begin
            if (p_sync && sync0) stray++;
            else begin
                rises++;
                if (first_rise_cyc < 0) first_rise_cyc = mc;
            end
        end
        if (p_sclk && !sclk0) begin
            if (p_sync && sync0) stray++;
            else if (!p_sync) begin
                falls++;
                for (int i = 0; i < 8; i++) sh[i] = {sh[i][14:0], p_sdi[i]};
            end
        end
        if (!p_sync && sync0) begin
            rise_cyc = mc;
            last_lowlen = mc - fall_cyc;
            last_first_rise = first_rise_cyc - fall_cyc;
            if (falls == 16 && rises == 16) begin
                for (int i = 0; i < 8; i++) w[16*i +: 16] = sh[i];
                dec_q.push_back(w);
            end else begin
                aborts++;
            end
        end
        p_sclk = sclk0;
        p_sync = sync0;
        p_sdi  = sdi0;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [15:0] base, input bit inc);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = inc ? base + 16'(i) : base;
        return w;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Hand one word to u0 and wait until it is ready again; lat = handshake-to-ready cycles
    task automatic send0(input logic [127:0] w, output int lat);
        int n;
        int t_acc;
        n = 0;
        data0  = w;
        valid0 = 1'b1;
        while (!ready0 && n < 200) begin tick(); n++; end
        check("accept_wait", 128'(n < 200), 128'(1));
        t_acc = cyc;
        exp_q.push_back(w);
        tick();
        valid0 = 1'b0;
        n = 0;
        while (!ready0 && n < 200) begin tick(); n++; end
        check("ready_wait", 128'(n < 200), 128'(1));
        lat = cyc - t_acc;
    endtask

    task automatic wait_ready0(input string tag);
        int n;
        n = 0;
        while (!ready0 && n < 200) begin tick(); n++; end
        check(tag, 128'(n < 200), 128'(1));
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, 128'(dec_q.size()), 128'(exp_q.size()));
        while (dec_q.size() > 0 && exp_q.size() > 0)
            check(tag, dec_q.pop_front(), exp_q.pop_front());
        dec_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, d_before, a_before, r, f, rd, t;
        int ld_before;
        logic [127:0] w, w1;
        logic ps;

        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", 128'(ready0), 128'(1));
        check("rst_sync",  128'(sync0),  128'(1));
        check("rst_sclk",  128'(sclk0),  128'(0));
        check("rst_sdi",   128'(sdi0),   128'(0));
        check("rst_done",  128'(done0),  128'(0));
`ifdef DAC_LDAC_EN
        check("rst_ldac",  128'(ldac0),  128'(1));
`endif
        tick();

        // Single frame of 16'hA5A0+i
        d_before = dones;
        ld_before = ldac_lows;
        send0(fill(16'hA5A0, 1'b1), lat);
        tick(); tick();
        check("single_lat",       128'(lat),             128'(S0 + 32 + H0 + 1));
        check("single_lowlen",    128'(last_lowlen),     128'(S0 + 32));
        check("single_firstrise", 128'(last_first_rise), 128'(S0));
        check("single_dones",     128'(dones - d_before), 128'(1));
        check("single_done_pos",  128'(done_cyc),        128'(rise_cyc));
`ifdef DAC_LDAC_EN
        check("ldac_count", 128'(ldac_lows - ld_before), 128'(1));
        check("ldac_pos",   128'(ldac_cyc - rise_cyc),   128'(H0 - 1));
        check("ldac_sync",  128'(ldac_bad),              128'(0));
`endif
        drain("single");

        // Random words
        for (int k = 0; k < 4; k++) begin
            send0(rand_word(), lat);
            check("rand_lat", 128'(lat), 128'(S0 + 32 + H0 + 1));
        end
        tick(); tick();
        drain("rand");

        // Back-to-back with data_valid held high
        data0 = fill(16'h0000, 1'b0);
        valid0 = 1'b1;
        wait_ready0("b2b_wait0");
        exp_q.push_back(data0);
        tick();
        data0 = fill(16'hFFFF, 1'b0);
        wait_ready0("b2b_wait1");
        exp_q.push_back(data0);
        tick();
        valid0 = 1'b0;
        wait_ready0("b2b_wait2");
        tick(); tick();
        // sync_n stays high for the HOLD cycles plus the single accepting IDLE cycle
        check("b2b_gap", 128'(last_gap), 128'(H0 + 1));
        drain("b2b");

        // Busy-ignore: data/valid activity during SHIFT must not disturb the frame
        w = fill(16'hC3C0, 1'b1);
        data0 = w;
        valid0 = 1'b1;
        wait_ready0("busy_wait0");
        exp_q.push_back(w);
        tick();
        valid0 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        for (int k = 0; k < 6; k++) begin
            data0 = fill(16'h1234, 1'b0);
            valid0 = (k % 2) == 0;
            tick();
        end
        valid0 = 1'b0;
        wait_ready0("busy_wait1");
        tick(); tick(); tick();
        check("busy_idle_sync", 128'(sync0), 128'(1));
        drain("busy");

        // Reset at the 8th sclk rise
        d_before = dones;
        a_before = aborts;
        data0 = rand_word();
        valid0 = 1'b1;
        wait_ready0("abort_wait0");
        tick();
        valid0 = 1'b0;
        r = 0;
        ps = sclk0;
        for (int n = 0; n < 100 && r < 8; n++) begin
            tick();
            if (sclk0 && !ps) r++;
            ps = sclk0;
        end
        check("abort_rises", 128'(r), 128'(8));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sync",  128'(sync0),  128'(1));
        check("abort_sclk",  128'(sclk0),  128'(0));
        check("abort_sdi",   128'(sdi0),   128'(0));
        check("abort_ready", 128'(ready0), 128'(1));
        check("abort_done",  128'(done0),  128'(0));
        tick(); tick(); tick();
        check("abort_count",   128'(aborts - a_before), 128'(1));
        check("abort_nodone",  128'(dones - d_before),  128'(0));
        check("abort_nodecode", 128'(dec_q.size()),     128'(0));
        send0(fill(16'h8001, 1'b0), lat);
        tick(); tick();
        check("post_abort_lat", 128'(lat), 128'(S0 + 32 + H0 + 1));
        drain("post_abort");

        // Second instance with SETUP=3, HOLD=4
        w1 = rand_word();
        data1 = w1;
        valid1 = 1'b1;
        check("d1_ready_idle", 128'(ready1), 128'(1));
        t = cyc; f = -1; r = -1; rd = -1;
        for (int n = 0; n < 80 && rd < 0; n++) begin
            tick();
            valid1 = 1'b0;
            if (f < 0 && !sync1) f = cyc;
            if (r < 0 && sclk1) r = cyc;
            if (rd < 0 && ready1) rd = cyc;
        end
        check("d1_sync_fall",  128'(f - t),  128'(1));
        check("d1_first_rise", 128'(r - f),  128'(S1));
        check("d1_ready_lat",  128'(rd - t), 128'(S1 + 32 + H1 + 1));

        check("stray_edges", 128'(stray), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
